// File: rtl/alu_sequencer_if.sv
// Bundle between alu_sequencer and its surroundings: instruction handshake,
// ALU drive/result, debug register read and the illegal-op pulse.
interface alu_sequencer_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  instr_valid_in;
    logic                  instr_ready_out;
    logic [15:0]           instr_in;
    logic                  alu_enable_out;
    logic [2:0]            alu_opcode_out;
    logic [DATA_WIDTH-1:0] alu_input1_out;
    logic [DATA_WIDTH-1:0] alu_input2_out;
    logic [DATA_WIDTH-1:0] alu_output_in;
    logic [1:0]            reg_rd_addr_in;
    logic [DATA_WIDTH-1:0] reg_rd_data_out;
    logic                  illegal_out;

    modport slave (
        input  instr_valid_in, instr_in, alu_output_in, reg_rd_addr_in,
        output instr_ready_out, alu_enable_out, alu_opcode_out,
               alu_input1_out, alu_input2_out, reg_rd_data_out, illegal_out
    );

    modport master (
        output instr_valid_in, instr_in, alu_output_in, reg_rd_addr_in,
        input  instr_ready_out, alu_enable_out, alu_opcode_out,
               alu_input1_out, alu_input2_out, reg_rd_data_out, illegal_out
    );
endinterface

// File: rtl/alu_sequencer.sv
// Issue stage for the 8-bit signed ALU: decodes instruction words, drives the
// ALU for its fixed latency and writes the result back to the register file.
module alu_sequencer #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REGS    = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic           clock_in,
    input  logic           reset_in,
    alu_sequencer_if.slave bus
);
    localparam logic [2:0] OP_ILL5 = 3'b101;
    localparam logic [2:0] OP_ILL6 = 3'b110;
    localparam logic [2:0] OP_LDI  = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [1:0]            rd_q, rd_d;
    logic                  en_q, en_d;
    logic                  ill_q, ill_d;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic [2:0]            f_op_s;
    logic                  f_imm_sel_s;
    logic [1:0]            f_rd_s, f_rs1_s, f_rs2_s;
    logic [DATA_WIDTH-1:0] f_imm_s;
    logic                  accept_s;

    assign f_op_s      = bus.instr_in[15:13];
    assign f_imm_sel_s = bus.instr_in[12];
    assign f_rd_s      = bus.instr_in[11:10];
    assign f_rs1_s     = bus.instr_in[9:8];
    assign f_rs2_s     = bus.instr_in[7:6];
    assign f_imm_s     = DATA_WIDTH'($signed(bus.instr_in[7:0]));
    assign accept_s    = bus.instr_valid_in & (state_q == S_IDLE);

    assign bus.instr_ready_out = (state_q == S_IDLE);
    assign bus.alu_enable_out  = en_q;
    assign bus.alu_opcode_out  = op_q;
    assign bus.alu_input1_out  = a_q;
    assign bus.alu_input2_out  = b_q;
    assign bus.illegal_out     = ill_q;
    assign bus.reg_rd_data_out = regs_q[bus.reg_rd_addr_in];

    // Decode, operand capture, latency countdown and writeback selection
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        en_d    = en_q;
        ill_d   = 1'b0;
        regs_d  = regs_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    case (f_op_s)
                        OP_LDI:           regs_d[f_rd_s] = f_imm_s;
                        OP_ILL5, OP_ILL6: ill_d = 1'b1;
                        default: begin
                            // Operands are latched here, so rd aliasing rs1/rs2 sees old values
                            op_d    = f_op_s;
                            a_d     = regs_q[f_rs1_s];
                            b_d     = f_imm_sel_s ? f_imm_s : regs_q[f_rs2_s];
                            rd_d    = f_rd_s;
                            cnt_d   = 4'(ALU_LATENCY);
                            en_d    = 1'b1;
                            state_d = S_EXEC;
                        end
                    endcase
                end else begin
                    en_d = 1'b0;
                end
            end
            S_EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    regs_d[rd_q] = bus.alu_output_in;
                    en_d         = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: begin
                en_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State, pipeline-control and register-file storage
    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= 2'd0;
            en_q    <= 1'b0;
            ill_q   <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            en_q    <= en_d;
            ill_q   <= ill_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// Directed plus random bench for alu_sequencer with a behavioural ALU stand-in.
module tb_alu_sequencer;
    localparam int DW  = 8;
    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] mregs [4];
    logic [7:0] p1_q, p2_q;

    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_WIDTH(DW)) bus ();

    alu_sequencer #(.DATA_WIDTH(DW), .NUM_REGS(4), .ALU_LATENCY(LAT)) dut (
        .clock_in (clk),
        .reset_in (rst_n),
        .bus      (bus)
    );

    function automatic logic [7:0] ref_alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            3'd0:    r = sa + sb;
            3'd1:    r = sa - sb;
            3'd2:    r = sa * sb;
            3'd3:    r = (sa == sb) ? 1 : 0;
            3'd4:    r = (sa > sb) ? 1 : 0;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    // ALU stand-in: result valid LAT edges after operands are presented
    always @(posedge clk) begin
        p1_q <= ref_alu(bus.alu_opcode_out, bus.alu_input1_out, bus.alu_input2_out);
        p2_q <= p1_q;
    end
    assign bus.alu_output_in = p2_q;

    function automatic logic [15:0] mk(input logic [2:0] op, input logic isel, input logic [1:0] rd,
                                       input logic [1:0] rs1, input logic [7:0] low);
        return {op, isel, rd, rs1, low};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            bus.reg_rd_addr_in = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), {24'd0, bus.reg_rd_data_out}, {24'd0, mregs[i]});
        end
    endtask

    // Called at a negedge; returns at the negedge after completion of the instruction.
    task automatic issue(input logic [15:0] w, input logic hold_v, input logic [15:0] hold_w);
        logic [2:0] op;
        logic [1:0] rd;
        logic [7:0] a, b, res;
        int guard;
        op = w[15:13];
        rd = w[11:10];
        bus.instr_valid_in = 1'b1;
        bus.instr_in       = w;
        guard = 0;
        while (bus.instr_ready_out !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("accept_wait", {31'd0, guard < 40}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid_in = hold_v;
        bus.instr_in       = hold_w;
        chk("illegal", {31'd0, bus.illegal_out}, {31'd0, (op == 3'd5 || op == 3'd6)});
        chk("ready_after_accept", {31'd0, bus.instr_ready_out}, {31'd0, (op > 3'd4)});
        if (op == 3'd7) begin
            mregs[rd] = w[7:0];
        end else if (op <= 3'd4) begin
            a   = mregs[w[9:8]];
            b   = w[12] ? w[7:0] : mregs[w[7:6]];
            res = ref_alu(op, a, b);
            chk("opcode", {29'd0, bus.alu_opcode_out}, {29'd0, op});
            chk("in1", {24'd0, bus.alu_input1_out}, {24'd0, a});
            chk("in2", {24'd0, bus.alu_input2_out}, {24'd0, b});
            chk("enable_exec", {31'd0, bus.alu_enable_out}, 32'd1);
            for (int k = 0; k < LAT; k++) begin
                @(negedge clk);
                chk("ready_exec", {31'd0, bus.instr_ready_out}, 32'd0);
                chk("enable_hold", {31'd0, bus.alu_enable_out}, 32'd1);
                bus.reg_rd_addr_in = rd;
                #1;
                chk("no_early_wb", {24'd0, bus.reg_rd_data_out}, {24'd0, mregs[rd]});
            end
            @(negedge clk);
            chk("ready_after_wb", {31'd0, bus.instr_ready_out}, 32'd1);
            chk("enable_idle", {31'd0, bus.alu_enable_out}, 32'd0);
            mregs[rd] = res;
        end
        check_regs("regs");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] w;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        rst_n = 1'b0;
        bus.instr_valid_in = 1'b1;
        bus.instr_in       = mk(3'd7, 1'b0, 2'd1, 2'd0, 8'h55);
        bus.reg_rd_addr_in = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        chk("rst_enable", {31'd0, bus.alu_enable_out}, 32'd0);
        chk("rst_opcode", {29'd0, bus.alu_opcode_out}, 32'd0);
        chk("rst_in1", {24'd0, bus.alu_input1_out}, 32'd0);
        chk("rst_in2", {24'd0, bus.alu_input2_out}, 32'd0);
        chk("rst_illegal", {31'd0, bus.illegal_out}, 32'd0);
        check_regs("rst");
        bus.instr_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back loads, then r3 = r1 + r2
        issue(mk(3'd7, 1'b0, 2'd1, 2'd0, 8'h05), 1'b1, mk(3'd7, 1'b0, 2'd2, 2'd0, 8'hFD));
        issue(mk(3'd7, 1'b0, 2'd2, 2'd0, 8'hFD), 1'b0, 16'h0000);
        issue(mk(3'd0, 1'b0, 2'd3, 2'd1, {2'd2, 6'd0}), 1'b0, 16'h0000);
        chk("add_r3", {24'd0, mregs[3]}, 32'h02);

        // Immediate and boundary ALU cases with r1 = 0x7F
        issue(mk(3'd7, 1'b0, 2'd1, 2'd0, 8'h7F), 1'b0, 16'h0000);
        issue(mk(3'd0, 1'b1, 2'd0, 2'd1, 8'h01), 1'b0, 16'h0000);
        chk("addimm_wrap", {24'd0, mregs[0]}, 32'h80);
        issue(mk(3'd2, 1'b0, 2'd0, 2'd1, {2'd1, 6'd0}), 1'b0, 16'h0000);
        chk("mul", {24'd0, mregs[0]}, 32'h01);
        issue(mk(3'd4, 1'b0, 2'd0, 2'd2, {2'd1, 6'd0}), 1'b0, 16'h0000);
        chk("gt", {24'd0, mregs[0]}, 32'h00);
        issue(mk(3'd3, 1'b1, 2'd3, 2'd1, 8'h7F), 1'b0, 16'h0000);
        chk("eqimm", {24'd0, mregs[3]}, 32'h01);

        // Illegal op followed immediately by a load
        issue(mk(3'd5, 1'b0, 2'd2, 2'd1, 8'h33), 1'b1, mk(3'd7, 1'b0, 2'd3, 2'd0, 8'h11));
        issue(mk(3'd7, 1'b0, 2'd3, 2'd0, 8'h11), 1'b0, 16'h0000);

        // rd == rs1, second word held on valid during EXEC
        issue(mk(3'd7, 1'b0, 2'd1, 2'd0, 8'h04), 1'b0, 16'h0000);
        issue(mk(3'd1, 1'b1, 2'd1, 2'd1, 8'h01), 1'b1, mk(3'd0, 1'b0, 2'd2, 2'd1, {2'd1, 6'd0}));
        chk("sub_alias", {24'd0, mregs[1]}, 32'h03);
        issue(mk(3'd0, 1'b0, 2'd2, 2'd1, {2'd1, 6'd0}), 1'b0, 16'h0000);
        chk("held_word", {24'd0, mregs[2]}, 32'h06);

        // Reset during EXEC aborts the writeback
        bus.instr_valid_in = 1'b1;
        bus.instr_in       = mk(3'd0, 1'b0, 2'd0, 2'd1, {2'd1, 6'd0});
        @(posedge clk);
        @(negedge clk);
        bus.instr_valid_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) mregs[i] = 8'h00;
        #1;
        chk("abort_enable", {31'd0, bus.alu_enable_out}, 32'd0);
        chk("abort_ready", {31'd0, bus.instr_ready_out}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_regs("abort");
        issue(mk(3'd7, 1'b0, 2'd2, 2'd0, 8'h22), 1'b0, 16'h0000);
        issue(mk(3'd0, 1'b0, 2'd3, 2'd2, {2'd2, 6'd0}), 1'b0, 16'h0000);
        chk("post_reset_add", {24'd0, mregs[3]}, 32'h44);

        // Random instruction stream against the model
        for (int n = 0; n < 60; n++) begin
            w = 16'($urandom);
            issue(w, 1'b0, 16'h0000);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Upstream issue stage for the 8-bit signed `alu`. It accepts 16-bit instruction words over a valid/ready handshake and decodes them. It reads operands from a small internal register file and drives the ALU's opcode, operand and enable inputs, holding them stable for the ALU's fixed latency. It then writes the ALU result back into the destination register.

## Interface
Parameters:
- `DATA_WIDTH`, 8, operand/register width; must match the ALU.
- `NUM_REGS`, 4, register count; index width is 2 bits and fixed by the instruction format.
- `ALU_LATENCY`, 2, edges from operands presented to the ALU until `alu_output_in` is valid; legal range 1–15.

Ports:
- `clock_in`  in  1  single clock; all state changes on the rising edge.
- `reset_in`  in  1  asynchronous, active-low reset.
- `instr_valid_in`  in  1  instruction word present.
- `instr_ready_out`  out  1  sequencer can accept an instruction.
- `instr_in`  in  16  instruction word.
- `alu_enable_out`  out  1  drives ALU `enable_in`.
- `alu_opcode_out`  out  3  drives ALU `opcode_in`.
- `alu_input1_out`  out  DATA_WIDTH  signed operand A.
- `alu_input2_out`  out  DATA_WIDTH  signed operand B.
- `alu_output_in`  in  DATA_WIDTH  ALU result.
- `reg_rd_addr_in`  in  2  debug read index.
- `reg_rd_data_out`  out  DATA_WIDTH  combinational read of `regs[reg_rd_addr_in]`.
- `illegal_out`  out  1  one-cycle pulse when an illegal opcode is accepted.

## Operation
- Instruction fields:
  - `[15:13]` op, `[12]` imm_sel, `[11:10]` rd, `[9:8]` rs1.
  - When imm_sel=0, `[7:6]` is rs2 and `[5:0]` is ignored.
  - When imm_sel=1, `[7:0]` is imm8, used as a signed operand B.
- Op codes:
  - 000 add, 001 sub, 010 mul, 011 eq, 100 gt (signed). All are forwarded to the ALU unchanged.
  - 111 load-immediate: rd ← imm8, with no ALU use. imm_sel is ignored.
  - 101 and 110 are illegal.
- Handshake: a transfer occurs on an edge where `instr_valid_in & instr_ready_out` is high. `instr_ready_out` = (state == IDLE).
- FSM states: IDLE and EXEC.
  - IDLE + transfer of an ALU op: capture op, rd, A = regs[rs1], and B = imm_sel ? imm8 : regs[rs2] into the output registers. Load counter = ALU_LATENCY. Move to EXEC.
  - IDLE + transfer of load-immediate: regs[rd] ← imm8 on the same edge. Stay in IDLE.
  - IDLE + transfer of an illegal op: `illegal_out` = 1 for the next cycle. No register write. Stay in IDLE.
  - EXEC, counter ≠ 0: decrement the counter. Hold opcode and operands stable.
  - EXEC, counter = 0: regs[rd] ← `alu_output_in`. Move to IDLE.
- Operands are sampled at acceptance, so rd == rs1/rs2 is safe and the old value is used.
- Results are written as full DATA_WIDTH bits. Compare ops yield 0x00 or 0x01. Arithmetic wraps mod 2^8 as produced by the ALU; the sequencer does no checking.
- Debug read port is combinational and shows a written value from the edge after the write.

## Timing
- Reset asserted: state IDLE, all regs = 0, `alu_enable_out` = 0, `alu_opcode_out` = 0, operands = 0, `illegal_out` = 0, `instr_ready_out` = 1. Handshakes are ignored while reset is asserted.
- Reset during EXEC: aborts the operation, with no writeback. The first acceptance is possible on the first edge after release.
- Accept edge T0 (ALU op):
  - Outputs become valid after T0, and `alu_enable_out` = 1 for edges T0+1 … T0+ALU_LATENCY+1.
  - Writeback occurs on edge T0+ALU_LATENCY+1; for the default, that is T0+3.
  - `instr_ready_out` is low from after T0 until after the writeback edge.
  - Throughput is one ALU op per ALU_LATENCY+2 cycles.
- Load-immediate and illegal ops occupy one cycle, so back-to-back acceptance is allowed.
- `alu_enable_out` = 0 in IDLE. Operand and opcode outputs hold their last values in IDLE.
- `instr_valid_in` high while `instr_ready_out` is low: the word is not consumed, and the upstream must hold it.

## Test plan
- Reset then debug-read all regs → 0 each. `instr_ready_out` = 1. `alu_enable_out` = 0.
- Load r1 = 0x05 and load r2 = 0xFD (−3) back-to-back, then add r3 = r1 + r2 → r3 = 0x02 at T0+3. ready is low for exactly 3 cycles.
- Run the ALU ops with immediates using r1 = 0x7F:
  - add-imm 0x01 → 0x80 (wrap).
  - mul r1·r1 → 0x01.
  - gt r2 > r1 → 0x00.
  - eq-imm 0x7F → 0x01.
- Issue op 101 → `illegal_out` pulses for 1 cycle, no register changes, and the next instruction is accepted on the following edge.
- rd = rs1: r1 = 0x04, sub r1 = r1 − imm 0x01 → r1 = 0x03. Hold valid high during EXEC with a second word → that word is accepted only after writeback.
- Assert reset one cycle after accepting add r0 = r1 + r1 → no writeback, all regs 0, and the first post-reset instruction executes normally.
